// File: rtl/mdv_sequencer_if.sv
// mdv_sequencer_if -- EX-stage multiply/divide sequencer bundle.
//
//   mdv_req   : EX holds a valid MDV-class instruction this cycle
//   mdv_op    : operation code (0 mult, 1 multu, 2 div, 3 divu,
//               4 mfhi, 5 mflo, 6 mthi, 7 mtlo; 8-15 ignored)
//   op_a/op_b : forwarded rs / rt values
//   flush     : cancels an issue attempted in the same cycle
//   stall     : pipeline freeze while an MDV instruction waits
//   busy      : a multiply or divide is in flight
//   rd_data   : HI for mfhi, LO for mflo, 0 otherwise
//   hi/lo     : architectural HI/LO registers
//   dbg_state : sequencer FSM state (0 IDLE, 1 MUL, 2 DIV)
//
// Handshake: the pipeline presents mdv_req/mdv_op/op_a/op_b for a cycle;
// the request is accepted on a rising edge where stall=0 and flush=0 and
// mdv_op is valid. While stall=1 the requester holds its request and the
// sequencer ignores op_a/op_b/mdv_op for the in-flight operation.
interface mdv_sequencer_if;
  logic        mdv_req;
  logic [3:0]  mdv_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic [31:0] rd_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  dbg_state;

  modport master (
    output mdv_req, mdv_op, op_a, op_b, flush,
    input  stall, busy, rd_data, hi, lo, dbg_state
  );

  modport slave (
    input  mdv_req, mdv_op, op_a, op_b, flush,
    output stall, busy, rd_data, hi, lo, dbg_state
  );
endinterface

// File: rtl/mdv_sequencer.sv
// mdv_sequencer -- multi-cycle HI/LO multiply/divide sequencer.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mdv_sequencer_if.slave (request, operands, flush in;
//           stall, busy, rd_data, hi, lo, dbg_state out)
//
// mult/multu and div/divu latch their operands at issue and hold the
// sequencer busy for MULT_CYCLES / DIV_CYCLES cycles; the result lands in
// HI/LO on the final busy edge. mthi/mtlo write HI/LO at issue, mfhi/mflo
// read them combinationally.
module mdv_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  mdv_sequencer_if.slave bus
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic             uns_q;   // latched mdv_op[0]: multu/divu
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;

  logic op_valid;
  logic stall;
  logic issue;

  assign op_valid = ~bus.mdv_op[3];
  assign stall    = bus.mdv_req & op_valid & (state != IDLE);
  assign issue    = bus.mdv_req & op_valid & ~stall & ~bus.flush;

  // Product: sign- or zero-extend to 64 bits; the low 64 bits of the
  // 64x64 product are the correct signed/unsigned 32x32 result.
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;

  always_comb begin
    a_ext = uns_q ? {32'd0, a_q} : {{32{a_q[31]}}, a_q};
    b_ext = uns_q ? {32'd0, b_q} : {{32{b_q[31]}}, b_q};
    prod  = a_ext * b_ext;
  end

  // Division on magnitudes, then signs restored: quotient negative when
  // operand signs differ, remainder follows the dividend. 0x80000000 / -1
  // falls out naturally: magnitude 0x80000000 negates to itself, rem 0.
  // A zero divisor is replaced by 1 only to keep the datapath X-free; the
  // result is discarded at completion in that case.
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [31:0] div_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] div_q;
  logic [31:0] div_r;

  always_comb begin
    a_neg = ~uns_q & a_q[31];
    b_neg = ~uns_q & b_q[31];
    a_abs = a_neg ? (32'd0 - a_q) : a_q;
    b_abs = b_neg ? (32'd0 - b_q) : b_q;
    div_b = (b_abs == 32'd0) ? 32'd1 : b_abs;
    q_mag = a_abs / div_b;
    r_mag = a_abs % div_b;
    div_q = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    div_r = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      uns_q <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            case (bus.mdv_op)
              4'd0, 4'd1: begin
                state <= MUL;
                cnt   <= CNT_W'(MULT_CYCLES);
                a_q   <= bus.op_a;
                b_q   <= bus.op_b;
                uns_q <= bus.mdv_op[0];
              end
              4'd2, 4'd3: begin
                state <= DIV;
                cnt   <= CNT_W'(DIV_CYCLES);
                a_q   <= bus.op_a;
                b_q   <= bus.op_b;
                uns_q <= bus.mdv_op[0];
              end
              4'd6:    hi_q <= bus.op_a;
              4'd7:    lo_q <= bus.op_a;
              default: ;  // mfhi/mflo: read-only
            endcase
          end
        end
        MUL, DIV: begin
          if (cnt == CNT_W'(1)) begin
            state <= IDLE;
            cnt   <= '0;
            if (state == MUL) begin
              hi_q <= prod[63:32];
              lo_q <= prod[31:0];
            end else if (b_q != 32'd0) begin
              hi_q <= div_r;
              lo_q <= div_q;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    case (bus.mdv_op)
      4'd4:    bus.rd_data = hi_q;
      4'd5:    bus.rd_data = lo_q;
      default: bus.rd_data = 32'd0;
    endcase
  end

  assign bus.stall     = stall;
  assign bus.busy      = (state != IDLE);
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_mdv_sequencer.sv
module tb_mdv_sequencer;

  logic clk;
  logic rst_n;

  mdv_sequencer_if bus ();

  mdv_sequencer #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          exp_busy;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[15];

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.mdv_req = 1'b0;
    bus.mdv_op  = 4'hF;
    bus.op_a    = '0;
    bus.op_b    = '0;
    bus.flush   = 1'b0;
  endtask

  // Counts negedge samples with busy=1, starting from the current sample.
  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy && n < 64) begin
      n++;
      @(negedge clk); #1;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    @(negedge clk);
    bus.mdv_req = 1'b1;
    bus.mdv_op  = v.op;
    bus.op_a    = v.a;
    bus.op_b    = v.b;
    bus.flush   = 1'b0;
    #1;
    check($sformatf("v%0d_issue_stall", idx), {31'd0, bus.stall}, 32'd0);
    @(negedge clk);
    // Scramble operands after issue: the latched copy must be used.
    bus.mdv_req = 1'b0;
    bus.mdv_op  = 4'hF;
    bus.op_a    = $urandom;
    bus.op_b    = $urandom;
    #1;
    count_busy(n);
    check($sformatf("v%0d_busy_cycles", idx), 32'(n), 32'(v.exp_busy));
    exp_q.push_back(v.exp_hi);
    exp_q.push_back(v.exp_lo);
    check($sformatf("v%0d_hi", idx), bus.hi, exp_q.pop_front());
    check($sformatf("v%0d_lo", idx), bus.lo, exp_q.pop_front());
  endtask

  // ---------------- test ----------------
  initial begin
    int n;

    vecs[0]  = '{4'd6, 32'h12345678, 32'h00000000, 0,  32'h12345678, 32'h00000000};
    vecs[1]  = '{4'd7, 32'h12345678, 32'h00000000, 0,  32'h12345678, 32'h12345678};
    vecs[2]  = '{4'd3, 32'h00000007, 32'h00000000, 10, 32'h12345678, 32'h12345678};
    vecs[3]  = '{4'd0, 32'hFFFFFFFE, 32'h00000003, 5,  32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[4]  = '{4'd1, 32'hFFFFFFFE, 32'h00000003, 5,  32'h00000002, 32'hFFFFFFFA};
    vecs[5]  = '{4'd2, 32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[6]  = '{4'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
    vecs[7]  = '{4'd3, 32'h00000064, 32'h00000007, 10, 32'h00000002, 32'h0000000E};
    vecs[8]  = '{4'd0, 32'h00010000, 32'h00010000, 5,  32'h00000001, 32'h00000000};
    vecs[9]  = '{4'd2, 32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
    vecs[10] = '{4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};
    vecs[11] = '{4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'h00000000, 32'h00000001};
    vecs[12] = '{4'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, 10, 32'hFFFFFFFF, 32'h00000003};
    vecs[13] = '{4'd9, 32'h00000005, 32'h00000005, 0,  32'hFFFFFFFF, 32'h00000003};
    vecs[14] = '{4'd4, 32'h00000000, 32'h00000000, 0,  32'hFFFFFFFF, 32'h00000003};

    // Reset state
    rst_n = 1'b0;
    idle_inputs();
    #2;
    check("rst_busy",  {31'd0, bus.busy},  32'd0);
    check("rst_stall", {31'd0, bus.stall}, 32'd0);
    check("rst_hi",    bus.hi, 32'd0);
    check("rst_lo",    bus.lo, 32'd0);
    check("rst_state", {30'd0, bus.dbg_state}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // mult 3*5, then mflo waits with changing operands
    @(negedge clk);
    bus.mdv_req = 1'b1; bus.mdv_op = 4'd0; bus.op_a = 32'd3; bus.op_b = 32'd5;
    #1;
    @(negedge clk);
    bus.mdv_op = 4'd5;
    #1;
    n = 0;
    while (bus.stall && n < 64) begin
      n++;
      @(negedge clk);
      bus.op_a = $urandom;
      bus.op_b = $urandom;
      #1;
    end
    check("mflo_stall_cycles", 32'(n), 32'd5);
    check("mflo_rd_data", bus.rd_data, 32'd15);
    check("mflo_hi", bus.hi, 32'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("mflo_no_busy", {31'd0, bus.busy}, 32'd0);

    // mult 2*3 with a second mult waiting: issues after completion
    @(negedge clk);
    bus.mdv_req = 1'b1; bus.mdv_op = 4'd0; bus.op_a = 32'd2; bus.op_b = 32'd3;
    #1;
    @(negedge clk);
    bus.op_a = 32'd4; bus.op_b = 32'd4;
    #1;
    n = 0;
    while (bus.stall && n < 64) begin
      n++;
      @(negedge clk); #1;
    end
    check("b2b_stall_cycles", 32'(n), 32'd5);
    check("b2b_first_lo", bus.lo, 32'd6);
    @(negedge clk);
    idle_inputs();
    #1;
    count_busy(n);
    check("b2b_second_busy", 32'(n), 32'd5);
    check("b2b_second_lo", bus.lo, 32'd16);

    // mthi then mfhi next cycle
    @(negedge clk);
    bus.mdv_req = 1'b1; bus.mdv_op = 4'd6; bus.op_a = 32'hDEADBEEF;
    #1;
    @(negedge clk);
    bus.mdv_op = 4'd4; bus.op_a = 32'd0;
    #1;
    check("mfhi_stall", {31'd0, bus.stall}, 32'd0);
    check("mfhi_rd_data", bus.rd_data, 32'hDEADBEEF);
    check("mthi_no_busy", {31'd0, bus.busy}, 32'd0);

    // flush suppresses a div issue in IDLE
    @(negedge clk);
    bus.mdv_req = 1'b1; bus.mdv_op = 4'd2; bus.op_a = 32'd100; bus.op_b = 32'd3;
    bus.flush = 1'b1;
    #1;
    @(negedge clk);
    idle_inputs();
    #1;
    check("flush_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk); #1;
    check("flush_busy_later", {31'd0, bus.busy}, 32'd0);
    check("flush_hi", bus.hi, 32'hDEADBEEF);
    check("flush_lo", bus.lo, 32'd16);

    // reset in the middle of a div
    @(negedge clk);
    bus.mdv_req = 1'b1; bus.mdv_op = 4'd2; bus.op_a = 32'd100; bus.op_b = 32'd3;
    #1;
    @(negedge clk);
    bus.mdv_op = 4'd4;  // mfhi waiting behind the div
    #1;
    @(negedge clk); #1;
    check("rst_mid_pre_stall", {31'd0, bus.stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy",  {31'd0, bus.busy},  32'd0);
    check("rst_mid_stall", {31'd0, bus.stall}, 32'd0);
    check("rst_mid_hi", bus.hi, 32'd0);
    check("rst_mid_lo", bus.lo, 32'd0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    // mult after reset, with flush held during its busy window
    @(negedge clk);
    bus.mdv_req = 1'b1; bus.mdv_op = 4'd0; bus.op_a = 32'd4; bus.op_b = 32'd5;
    #1;
    @(negedge clk);
    idle_inputs();
    bus.flush = 1'b1;
    #1;
    count_busy(n);
    check("post_rst_busy", 32'(n), 32'd5);
    check("post_rst_hi", bus.hi, 32'd0);
    check("post_rst_lo", bus.lo, 32'd20);
    bus.flush = 1'b0;

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdv_sequencer.md
MDV_SEQUENCER -- requirements
Module: mdv_sequencer

Interface
REQ-001 The block SHALL run on one clock, with reset asynchronous and active-low; ports are named clk and rst_n.
REQ-002 Parameter MULT_CYCLES SHALL default to 5: busy cycles for mult/multu.
REQ-003 Parameter DIV_CYCLES SHALL default to 10: busy cycles for div/divu.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 mdv_req  in  1  EX stage holds a valid MDV-class instruction this cycle.
REQ-007 mdv_op  in  4  MDVOPTION encoding: mult=0, multu=1, div=2, divu=3, mfhi=4, mflo=5, mthi=6, mtlo=7; codes 8-15 are ignored (no issue, no stall).
REQ-008 op_a  in  32  forwarded R_rs value.
REQ-009 op_b  in  32  forwarded R_rt value.
REQ-010 flush  in  1  exception/eret flush; cancels an issue attempted in the same cycle.
REQ-011 stall  out  1  freezes IF/ID/EX while an MDV instruction waits.
REQ-012 busy  out  1  a multiply or divide is in flight.
REQ-013 rd_data  out  32  HI for mfhi, LO for mflo, 0 otherwise.
REQ-014 hi, lo  out  32 each  architectural HI/LO registers.

Function
REQ-015 The FSM SHALL have states IDLE, MUL and DIV, with a countdown counter cnt wide enough for max(MULT_CYCLES, DIV_CYCLES).
REQ-016 issue SHALL equal mdv_req && valid mdv_op && !stall && !flush.
REQ-017 stall SHALL be combinational: mdv_req && valid mdv_op && state!=IDLE; the block never stalls in IDLE.
REQ-018 Issue of mult/multu in IDLE SHALL latch op_a/op_b and the op, set state MUL and load cnt=MULT_CYCLES.
REQ-019 Issue of div/divu in IDLE SHALL latch the operands, set state DIV and load cnt=DIV_CYCLES.
REQ-020 busy SHALL be 1 exactly when state!=IDLE, i.e. for MULT_CYCLES or DIV_CYCLES consecutive cycles after the issue edge.
REQ-021 In MUL/DIV, cnt SHALL decrement each cycle; on the edge where cnt==1, HI/LO SHALL be written, state SHALL return to IDLE and cnt SHALL become 0.
REQ-022 mult SHALL produce {HI,LO} = signed 32x32 -> 64 product; multu SHALL produce the unsigned product.
REQ-023 div SHALL produce LO = quotient truncated toward zero and HI = remainder carrying the dividend's sign; divu SHALL use the unsigned equivalents.
REQ-024 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-025 A divisor of 0 SHALL leave HI/LO unchanged at completion; the busy timing is unchanged.
REQ-026 mthi/mtlo SHALL write op_a into HI/LO on the issue edge, with no busy cycle.
REQ-027 mfhi/mflo SHALL cause no state change; rd_data SHALL be combinational from the current hi/lo and is valid whenever stall=0.
REQ-028 flush SHALL NOT abort an in-flight operation; it only suppresses same-cycle issue.
REQ-029 While stall=1, op_a/op_b/mdv_op changes SHALL NOT affect the latched in-flight operands.
REQ-030 In the completion cycle (cnt==1) a waiting mdv_req SHALL still see stall=1; it issues on the following cycle with the updated HI/LO.

Reset
REQ-031 When rst_n=0, the block SHALL immediately set state=IDLE, cnt=0, hi=0, lo=0, latched operands=0, busy=0 and stall=0, independent of clk.
REQ-032 Reset asserted mid-operation SHALL discard the in-flight result, leaving HI/LO at 0.
REQ-033 Outputs SHALL be stable from the first rising clk edge after rst_n deasserts.

Verification
REQ-034 mult op_a=0xFFFFFFFE (-2), op_b=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-035 div op_a=0xFFFFFFF9 (-7), op_b=2 -> busy high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 7/0 with hi=lo=0x12345678 beforehand -> both unchanged.
REQ-036 mult issued, then mflo asserted with mdv_req on the next cycle -> stall=1 through the completion cycle, then stall=0 and rd_data equals the new lo.
REQ-037 mthi 0xDEADBEEF followed by mfhi the next cycle -> no stall, rd_data=0xDEADBEEF.
REQ-038 mdv_req=1, op=div, flush=1 in IDLE -> no issue, busy stays 0, hi/lo unchanged.
REQ-039 rst_n pulsed low at cycle 3 of a div -> busy=0, hi=lo=0 immediately; a subsequent mult completes normally after 5 cycles.
